dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the pipeline's MEM stage and the 128-bit block data memory. It serves 32-bit word loads and stores from a small tag/data store. On a miss it sequences the block memory itself: write-back of a dirty victim, then block fill. It stalls the pipeline through BUSYWAIT until the access can complete.

## Interface
- NUM_BLOCKS, 8, cache lines; power of two; index width IW = log2(NUM_BLOCKS) = 3.
- CLOCK  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous, active-low reset.
- READ  in  1  CPU word load request.
- WRITE  in  1  CPU word store request.
- ADDRESS  in  32  CPU byte address.
  - [1:0] ignored; [3:2] word offset; [3+IW:4] index; [31:4+IW] tag (25 bits at default).
- WRITEDATA  in  32  store data.
- READDATA  out  32  load data; valid when READ=1 and BUSYWAIT=0.
- BUSYWAIT  out  1  stall to the pipeline.
- MEM_READ  out  1  block read request to data memory.
- MEM_WRITE  out  1  block write request to data memory.
- MEM_ADDRESS  out  28  block address {tag, index}.
- MEM_WRITEDATA  out  128  victim block; word 0 in [31:0].
- MEM_READDATA  in  128  fill block; word 0 in [31:0].
- MEM_BUSYWAIT  in  1  memory busy.
  - High combinationally whenever MEM_READ or MEM_WRITE is high, until the transfer completes.

## Operation
- Per-line storage: valid bit, dirty bit, tag, 128-bit data. Byte n of the block maps to MEM bits [8n+7:8n].
- Request: exactly one of READ or WRITE is high.
  - READ=WRITE=1 is illegal. It is ignored: no state change, BUSYWAIT=0, READDATA=0.
- Hit: line valid and stored tag equals the ADDRESS tag.
  - Read hit: READDATA = selected word, combinational; BUSYWAIT=0.
  - Write hit: selected word written at the next posedge; dirty set to 1; BUSYWAIT=0.
- Miss: BUSYWAIT=1 combinationally in the same cycle.
- FSM states and transitions:
  - IDLE: on a miss with the victim valid and dirty, go to WRITEBACK. On any other miss, go to ALLOCATE.
  - WRITEBACK:
    - Drives MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA = victim block.
    - At a posedge with MEM_BUSYWAIT=0, go to ALLOCATE.
  - ALLOCATE:
    - Drives MEM_READ=1, MEM_ADDRESS={request tag, index}.
    - At a posedge with MEM_BUSYWAIT=0: data←MEM_READDATA, tag←request tag, valid←1, dirty←0; go to IDLE.
  - The retried access then hits in IDLE. A store merges on that cycle and sets dirty.
- MEM_READ and MEM_WRITE are never high together. Both are 0 in IDLE.
- BUSYWAIT is 1 throughout WRITEBACK and ALLOCATE.
- The CPU holds READ/WRITE/ADDRESS/WRITEDATA stable while BUSYWAIT=1.
  - If the request drops mid-miss, the current memory transfer still completes and the line is installed.
- Reset (RESET_N=0, asynchronous), applied immediately:
  - state=IDLE; all valid and dirty bits = 0; MEM_READ=MEM_WRITE=0; BUSYWAIT=0; READDATA=0.
  - Tag and data contents are don't-care.
  - Reset mid-WRITEBACK or mid-ALLOCATE aborts the transfer. Dirty data is lost (accepted).

## Timing
- Hit: zero stall cycles. Read data is combinational; the store commits at the posedge ending the request cycle.
- Clean miss, memory latency L cycles (MEM_BUSYWAIT high L cycles from request):
  - 1 IDLE cycle + L+1 ALLOCATE cycles, then 1 hit cycle.
  - BUSYWAIT is high for L+2 cycles.
- Dirty miss: additional L+1 WRITEBACK cycles before ALLOCATE.
- Outputs:
  - MEM_* are Moore outputs of the state register.
  - BUSYWAIT and READDATA are combinational from state, the request and the line lookup.
- Memory-side completion is defined only by sampling MEM_BUSYWAIT=0 at a posedge while the request is asserted. No fixed-latency assumption is made.
- RESET_N deassertion is synchronised by the integrator. The block takes no action on the deassertion edge.

## Test plan
- Reset then read 0x0000_0040 → BUSYWAIT=1; MEM_READ=1 with MEM_ADDRESS=0x0000004 until MEM_BUSYWAIT falls. Then READDATA = MEM_READDATA[31:0] with BUSYWAIT=0; total stall L+2 cycles.
- After the fill, read 0x0000_0048 → hit with zero stall; READDATA = fill bits [95:64]; no MEM_READ.
- Write 0xDEADBEEF to 0x0000_0044 (hit) → no memory traffic, dirty=1. Then read 0x0000_0044 → 0xDEADBEEF.
- Read 0x0000_00C0 (same index 4, tag 1) while the line is dirty:
  - WRITEBACK first: MEM_WRITE=1, MEM_ADDRESS=0x0000004, MEM_WRITEDATA[63:32]=0xDEADBEEF.
  - Then ALLOCATE with MEM_ADDRESS=0x000000C.
  - MEM_READ and MEM_WRITE are never high together.
- Assert RESET_N=0 mid-ALLOCATE → MEM_READ and BUSYWAIT drop the same timestep. A following read of a previously filled address misses.
- READ=WRITE=1 at 0x0000_0044 → BUSYWAIT=0, READDATA=0, no memory request, line contents unchanged.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller that
// sits between the MEM stage and a 128-bit block data memory.
//
// Ports:
//   CLOCK, RESET_N            clock, async active-low reset
//   READ, WRITE               CPU word load / store request
//   ADDRESS, WRITEDATA        CPU byte address and store data
//   READDATA, BUSYWAIT        load data and pipeline stall
//   MEM_READ, MEM_WRITE       block memory read / write requests
//   MEM_ADDRESS               block address {tag, index}
//   MEM_WRITEDATA             victim block (word 0 in [31:0])
//   MEM_READDATA              fill block (word 0 in [31:0])
//   MEM_BUSYWAIT              block memory busy
module dcache_controller #(
    parameter int NUM_BLOCKS = 8
) (
    input  logic         CLOCK,
    input  logic         RESET_N,
    input  logic         READ,
    input  logic         WRITE,
    input  logic [31:0]  ADDRESS,
    input  logic [31:0]  WRITEDATA,
    output logic [31:0]  READDATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    localparam int IW = $clog2(NUM_BLOCKS);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_e;

    state_e state_q, state_d;

    logic [NUM_BLOCKS-1:0] valid_q;
    logic [NUM_BLOCKS-1:0] dirty_q;
    logic [TW-1:0]         tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    // Miss address is captured so the transfer can finish even if the
    // CPU drops its request mid-miss.
    logic [IW-1:0] miss_idx_q, miss_idx_d;
    logic [TW-1:0] miss_tag_q, miss_tag_d;

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [1:0]    off;
    logic          req_rd;
    logic          req_wr;
    logic          req;
    logic          hit;
    logic          miss;
    logic          idle;
    logic          wr_hit;
    logic          fill;
    logic [127:0]  line;
    logic [31:0]   word;
    logic          unused_addr;

    assign idx = ADDRESS[3+IW:4];
    assign tag = ADDRESS[31:4+IW];
    assign off = ADDRESS[3:2];

    assign unused_addr = ^ADDRESS[1:0];

    // READ and WRITE together is an illegal request and is ignored.
    assign req_rd = READ & ~WRITE;
    assign req_wr = WRITE & ~READ;
    assign req    = req_rd | req_wr;

    assign idle = (state_q == S_IDLE);
    assign hit  = valid_q[idx] && (tag_q[idx] == tag);
    assign miss = req & ~hit;

    assign line = data_q[idx];
    assign word = line[{off, 5'b0} +: 32];

    assign wr_hit = idle & req_wr & hit;
    assign fill   = (state_q == S_ALLOCATE) & ~MEM_BUSYWAIT;

    // Gating with RESET_N keeps the stall and data low during reset even
    // while the CPU still presents a request.
    assign BUSYWAIT = RESET_N & (~idle | miss);
    assign READDATA = (RESET_N & idle & req_rd & hit) ? word : '0;

    assign MEM_READ      = (state_q == S_ALLOCATE);
    assign MEM_WRITE     = (state_q == S_WRITEBACK);
    assign MEM_WRITEDATA = data_q[miss_idx_q];
    assign MEM_ADDRESS   = MEM_WRITE ? {tag_q[miss_idx_q], miss_idx_q}
                                     : {miss_tag_q, miss_idx_q};

    always_comb begin
        state_d    = state_q;
        miss_idx_d = miss_idx_q;
        miss_tag_d = miss_tag_q;
        unique case (state_q)
            S_IDLE: begin
                if (miss) begin
                    miss_idx_d = idx;
                    miss_tag_d = tag;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                if (!MEM_BUSYWAIT) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_idx_q <= miss_idx_d;
            miss_tag_q <= miss_tag_d;
            if (fill) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
            if (wr_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data contents need no reset; valid bits guard them.
    always_ff @(posedge CLOCK) begin
        if (fill) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= MEM_READDATA;
        end
        if (wr_hit) begin
            data_q[idx][{off, 5'b0} +: 32] <= WRITEDATA;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios followed
// by random loads/stores against a block-level cache and memory model.
module tb_dcache_controller;

    logic         CLOCK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         READ = 1'b0;
    logic         WRITE = 1'b0;
    logic [31:0]  ADDRESS = '0;
    logic [31:0]  WRITEDATA = '0;
    logic [31:0]  READDATA;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    dcache_controller dut (
        .CLOCK         (CLOCK),
        .RESET_N       (RESET_N),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] blk_init(input int a);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) begin
            b[w*32 +: 32] = 32'hA500_0000 + 32'(a * 16 + w) * 32'h0101;
        end
        return b;
    endfunction

    // Block memory responder: busy for lat cycles per transfer.
    logic [127:0] mem [32];
    int           lat = 2;
    int           cnt = 0;
    int           wb_cnt = 0;
    int           rd_cnt = 0;
    logic [27:0]  wb_addr = '0;
    logic [127:0] wb_data = '0;
    logic [27:0]  rd_addr = '0;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt < lat);
    assign MEM_READDATA = mem[MEM_ADDRESS[4:0]];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= blk_init(i);
    end

    always @(posedge CLOCK) begin
        if (MEM_READ | MEM_WRITE) begin
            if (!MEM_BUSYWAIT) begin
                cnt <= 0;
                if (MEM_WRITE) begin
                    mem[MEM_ADDRESS[4:0]] <= MEM_WRITEDATA;
                    wb_cnt  <= wb_cnt + 1;
                    wb_addr <= MEM_ADDRESS;
                    wb_data <= MEM_WRITEDATA;
                end
                if (MEM_READ) begin
                    rd_cnt  <= rd_cnt + 1;
                    rd_addr <= MEM_ADDRESS;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    // Reference model: lines hold a whole block address plus its data.
    bit           mvalid [8];
    bit           mdirty [8];
    logic [27:0]  mblk   [8];
    logic [127:0] mdata  [8];
    logic [127:0] ref_mem [32];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mvalid[i] = 0;
            mdirty[i] = 0;
        end
    endtask

    task automatic access(input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input string nm);
        int           idx = int'(a[6:4]);
        int           off = int'(a[3:2]);
        logic [27:0]  ba = a[31:4];
        bit           legal = rd ^ wr;
        bit           hit = mvalid[idx] && (mblk[idx] == ba);
        bit           miss = legal && !hit;
        bit           wb = miss && mvalid[idx] && mdirty[idx];
        logic [27:0]  wba = mblk[idx];
        logic [127:0] wbd = mdata[idx];
        int           exp_stall = 0;
        int           wb0 = wb_cnt;
        int           rd0 = rd_cnt;
        int           stall = 0;
        bit           both = 0;
        bit           tout = 0;
        logic [31:0]  rdv;
        logic         mreq;
        logic [31:0]  exp_rd;
        if (miss) exp_stall = lat + 2 + (wb ? lat + 1 : 0);
        if (miss) begin
            if (wb) ref_mem[wba[4:0]] = wbd;
            mdata[idx]  = ref_mem[ba[4:0]];
            mblk[idx]   = ba;
            mvalid[idx] = 1;
            mdirty[idx] = 0;
        end
        if (legal && wr) begin
            mdata[idx][off*32 +: 32] = wd;
            mdirty[idx] = 1;
        end
        exp_rd = (rd && !wr) ? mdata[idx][off*32 +: 32] : 32'h0;
        READ = rd;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = wd;
        while (1) begin
            @(negedge CLOCK);
            if (!BUSYWAIT) break;
            if (MEM_READ && MEM_WRITE) both = 1;
            stall++;
            if (stall > 300) begin
                tout = 1;
                break;
            end
        end
        rdv = READDATA;
        mreq = MEM_READ | MEM_WRITE;
        @(posedge CLOCK);
        #1;
        READ = 0;
        WRITE = 0;
        chk({nm, " timeout"}, 128'(tout), 128'd0);
        chk({nm, " stall"}, 128'(stall), 128'(exp_stall));
        if (rd) chk({nm, " rdata"}, 128'(rdv), 128'(exp_rd));
        chk({nm, " rd&wr"}, 128'(both), 128'd0);
        chk({nm, " mem idle"}, 128'(mreq), 128'd0);
        chk({nm, " wb count"}, 128'(wb_cnt - wb0), 128'(wb ? 1 : 0));
        chk({nm, " fill count"}, 128'(rd_cnt - rd0), 128'(miss ? 1 : 0));
        if (wb) begin
            chk({nm, " wb addr"}, 128'(wb_addr), 128'(wba));
            chk({nm, " wb data"}, wb_data, wbd);
        end
        if (miss) chk({nm, " fill addr"}, 128'(rd_addr), 128'(ba));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = blk_init(i);
        model_reset();

        // Reset state with a request already presented
        READ = 1;
        ADDRESS = 32'h0000_0040;
        #12;
        chk("reset busywait", 128'(BUSYWAIT), 128'd0);
        chk("reset mem_read", 128'(MEM_READ), 128'd0);
        chk("reset mem_write", 128'(MEM_WRITE), 128'd0);
        chk("reset readdata", 128'(READDATA), 128'd0);
        READ = 0;
        @(negedge CLOCK);
        RESET_N = 1;
        @(posedge CLOCK);
        #1;

        lat = 2;
        access(1, 0, 32'h0000_0040, 0, "rd40 miss");
        access(1, 0, 32'h0000_0048, 0, "rd48 hit");
        access(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, "wr44 hit");
        access(1, 0, 32'h0000_0044, 0, "rd44 hit");
        access(1, 0, 32'h0000_00C0, 0, "rdC0 dirty");
        chk("wb word1", 128'(wb_data[63:32]), 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);

        // Illegal requests leave everything untouched
        access(1, 1, 32'h0000_0044, 32'h1111_2222, "illegal 44");
        access(1, 1, 32'h0000_00C4, 32'h3333_4444, "illegal C4");
        access(1, 0, 32'h0000_00C4, 0, "rdC4 after illegal");

        // Reset in the middle of a fill
        lat = 6;
        READ = 1;
        ADDRESS = 32'h0000_0150;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1;
        chk("mid alloc mem_read", 128'(MEM_READ), 128'd1);
        chk("mid alloc busywait", 128'(BUSYWAIT), 128'd1);
        RESET_N = 0;
        #1;
        chk("abort mem_read", 128'(MEM_READ), 128'd0);
        chk("abort mem_write", 128'(MEM_WRITE), 128'd0);
        chk("abort busywait", 128'(BUSYWAIT), 128'd0);
        chk("abort readdata", 128'(READDATA), 128'd0);
        READ = 0;
        model_reset();
        @(posedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1;
        @(posedge CLOCK);
        #1;
        lat = 1;
        access(1, 0, 32'h0000_00C4, 0, "rdC4 after reset");

        // Random loads and stores over 4 tags and all 8 indices
        for (int t = 0; t < 200; t++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            lat = $urandom_range(0, 3);
            a = (32'($urandom_range(0, 3)) << 7)
              | (32'($urandom_range(0, 7)) << 4)
              | 32'($urandom_range(0, 15));
            if (op == 0) access(1, 1, a, $urandom, "rand illegal");
            else if (op < 6) access(1, 0, a, 0, "rand rd");
            else access(0, 1, a, $urandom, "rand wr");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
